// File: rtl/symbol_feeder_pkg.sv
// Shared widths and FSM encodings for the symbol feeder.
// Imported by symbol_feeder and symbol_out_reg.
package symbol_feeder_pkg;

  localparam int BYTE_W = 8;
  localparam int CHAR_W = 16;

  typedef enum logic [1:0] {
    ST_HIGH = 2'd0,
    ST_LOW  = 2'd1,
    ST_DONE = 2'd2
  } feed_state_e;

endpackage

// File: rtl/symbol_out_reg.sv
// One-entry valid/ready holding register for character, first flag, offset.
// Ports: clock, reset, load/load_char in, out_ready in; character/valid/first/offset out.
module symbol_out_reg
  import symbol_feeder_pkg::*;
#(
  parameter int OFFSET_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [CHAR_W-1:0]   load_char,
  input  logic                out_ready,
  output logic [CHAR_W-1:0]   character,
  output logic                out_valid,
  output logic                out_first,
  output logic [OFFSET_W-1:0] offset
);

  logic [CHAR_W-1:0]   char_q, char_d;
  logic                valid_q, valid_d;
  logic                first_q, first_d;
  logic                seen_q, seen_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic                consume;

  assign consume = valid_q && out_ready;

  // offset_q always names the slot of the presented (or next) character,
  // so a load in the same cycle as a consume picks up the advanced value.
  always_comb begin
    char_d   = char_q;
    valid_d  = valid_q;
    first_d  = first_q;
    seen_d   = seen_q | consume;
    offset_d = offset_q + OFFSET_W'(consume);
    if (load) begin
      char_d  = load_char;
      valid_d = 1'b1;
      first_d = !seen_d;
    end else if (consume) begin
      valid_d = 1'b0;
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      char_q   <= '0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      seen_q   <= 1'b0;
      offset_q <= '0;
    end else begin
      char_q   <= char_d;
      valid_q  <= valid_d;
      first_q  <= first_d;
      seen_q   <= seen_d;
      offset_q <= offset_d;
    end
  end

  assign character = char_q;
  assign out_valid = valid_q;
  assign out_first = first_q;
  assign offset    = offset_q;

endmodule

// File: rtl/symbol_feeder.sv
// Pairs a byte stream into 16-bit characters for the STE array.
// Ports: byte_* stream in, character/char_* handshake out, stream_done, odd_dropped.
module symbol_feeder
  import symbol_feeder_pkg::*;
#(
  parameter int OFFSET_W   = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [BYTE_W-1:0]   byte_in,
  input  logic                byte_valid,
  input  logic                byte_last,
  output logic                byte_ready,
  output logic [CHAR_W-1:0]   character,
  output logic                char_valid,
  input  logic                char_ready,
  output logic                char_first,
  output logic [OFFSET_W-1:0] symbol_offset,
  output logic                stream_done,
  output logic                odd_dropped
);

  feed_state_e       state_q, state_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic              odd_q, odd_d;
  logic              done_q, done_d;
  logic              accept;
  logic              load;
  logic [CHAR_W-1:0] pair;

  // High bytes never block; the low byte waits for room in the output reg.
  assign byte_ready = (state_q != ST_DONE) &&
                      (state_q == ST_HIGH || !char_valid || char_ready);
  assign accept = byte_valid && byte_ready;
  assign load   = accept && (state_q == ST_LOW);
  assign pair   = BIG_ENDIAN ? {hi_q, byte_in} : {byte_in, hi_q};

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    odd_d   = odd_q;
    done_d  = done_q | ((state_q == ST_DONE) && !char_valid);
    unique case (state_q)
      ST_HIGH: begin
        if (accept) begin
          if (byte_last) begin
            state_d = ST_DONE;
            odd_d   = 1'b1;
          end else begin
            state_d = ST_LOW;
            hi_d    = byte_in;
          end
        end
      end
      ST_LOW: begin
        if (accept) state_d = byte_last ? ST_DONE : ST_HIGH;
      end
      default: state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_HIGH;
      hi_q    <= '0;
      odd_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      odd_q   <= odd_d;
      done_q  <= done_d;
    end
  end

  symbol_out_reg #(.OFFSET_W(OFFSET_W)) u_out (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .load_char (pair),
    .out_ready (char_ready),
    .character (character),
    .out_valid (char_valid),
    .out_first (char_first),
    .offset    (symbol_offset)
  );

  assign stream_done = done_q;
  assign odd_dropped = odd_q;

endmodule

// File: tb/tb_symbol_feeder.sv
// Directed bench for symbol_feeder: big-endian, little-endian and 2-bit offset
// instances share one byte stream.
module tb_symbol_feeder;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_last;
  logic        char_ready;

  logic        b_ready, b_valid, b_first, b_done, b_odd;
  logic [15:0] b_char;
  logic [31:0] b_off;

  logic        l_ready, l_valid, l_first, l_done, l_odd;
  logic [15:0] l_char;
  logic [31:0] l_off;

  logic        o_ready, o_valid, o_first, o_done, o_odd;
  logic [15:0] o_char;
  logic [1:0]  o_off;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  symbol_feeder dut (
    .clock(clock), .reset(reset), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(b_ready),
    .character(b_char), .char_valid(b_valid), .char_ready(char_ready),
    .char_first(b_first), .symbol_offset(b_off),
    .stream_done(b_done), .odd_dropped(b_odd)
  );

  symbol_feeder #(.BIG_ENDIAN(1'b0)) dut_le (
    .clock(clock), .reset(reset), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(l_ready),
    .character(l_char), .char_valid(l_valid), .char_ready(char_ready),
    .char_first(l_first), .symbol_offset(l_off),
    .stream_done(l_done), .odd_dropped(l_odd)
  );

  symbol_feeder #(.OFFSET_W(2)) dut_o2 (
    .clock(clock), .reset(reset), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(o_ready),
    .character(o_char), .char_valid(o_valid), .char_ready(char_ready),
    .char_first(o_first), .symbol_offset(o_off),
    .stream_done(o_done), .odd_dropped(o_odd)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] b, input logic l);
    byte_valid = v;
    byte_in    = b;
    byte_last  = l;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    char_ready = 1'b1;
    do_reset();
    #1;
    chk("rst_valid", 32'(b_valid), 32'd0);
    chk("rst_char",  32'(b_char),  32'd0);
    chk("rst_off",   b_off,        32'd0);
    chk("rst_first", 32'(b_first), 32'd0);
    chk("rst_done",  32'(b_done),  32'd0);
    chk("rst_odd",   32'(b_odd),   32'd0);
    chk("rst_ready", 32'(b_ready), 32'd1);

    // Stream 41 43 54 47, consumer always ready.
    drive(1'b1, 8'h41, 1'b0);
    step(); drive(1'b1, 8'h43, 1'b0);
    step(); drive(1'b1, 8'h54, 1'b0); #1;
    chk("t1_c0_char",  32'(b_char),  32'h4143);
    chk("t1_c0_valid", 32'(b_valid), 32'd1);
    chk("t1_c0_first", 32'(b_first), 32'd1);
    chk("t1_c0_off",   b_off,        32'd0);
    chk("t2_le_char",  32'(l_char),  32'h4341);
    step(); drive(1'b1, 8'h47, 1'b1); #1;
    chk("t1_bubble",   32'(b_valid), 32'd0);
    step(); drive(1'b0, 8'h00, 1'b0); #1;
    chk("t1_c1_char",  32'(b_char),  32'h5447);
    chk("t1_c1_valid", 32'(b_valid), 32'd1);
    chk("t1_c1_first", 32'(b_first), 32'd0);
    chk("t1_c1_off",   b_off,        32'd1);
    chk("t1_ready_dn", 32'(b_ready), 32'd0);
    step(); #1;
    chk("t1_drained",  32'(b_valid), 32'd0);
    chk("t1_done_lag", 32'(b_done),  32'd0);
    step(); #1;
    chk("t1_done",     32'(b_done),  32'd1);
    chk("t1_odd",      32'(b_odd),   32'd0);

    // Odd trailing byte is dropped.
    do_reset();
    drive(1'b1, 8'h41, 1'b0);
    step(); drive(1'b1, 8'h43, 1'b0);
    step(); drive(1'b1, 8'h47, 1'b1); #1;
    chk("t3_char",     32'(b_char),  32'h4143);
    step(); drive(1'b0, 8'h00, 1'b0); #1;
    chk("t3_odd",      32'(b_odd),   32'd1);
    chk("t3_valid",    32'(b_valid), 32'd0);
    chk("t3_ready",    32'(b_ready), 32'd0);
    step(); drive(1'b1, 8'h54, 1'b0); #1;
    chk("t3_done",     32'(b_done),  32'd1);
    chk("t3_ready2",   32'(b_ready), 32'd0);
    step(); #1;
    chk("t3_no_char",  32'(b_valid), 32'd0);

    // Back-pressure, then same-cycle load and consume.
    do_reset();
    char_ready = 1'b0;
    drive(1'b1, 8'h41, 1'b0);
    step(); drive(1'b1, 8'h43, 1'b0);
    step(); drive(1'b1, 8'h54, 1'b0); #1;
    chk("t4_hi_rdy",   32'(b_ready), 32'd1);
    step(); drive(1'b1, 8'h47, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_hold_chr", 32'(b_char),  32'h4143);
      chk("t4_hold_blk", 32'(b_ready), 32'd0);
      step();
    end
    char_ready = 1'b1; #1;
    chk("t4_rdy_on",   32'(b_ready), 32'd1);
    chk("t4_off0",     b_off,        32'd0);
    step(); char_ready = 1'b0; drive(1'b0, 8'h00, 1'b0); #1;
    chk("t4_nobubble", 32'(b_valid), 32'd1);
    chk("t4_c1_char",  32'(b_char),  32'h5447);
    chk("t4_c1_off",   b_off,        32'd1);
    chk("t4_c1_first", 32'(b_first), 32'd0);
    char_ready = 1'b1;
    step(); step(); #1;
    chk("t4_done",     32'(b_done),  32'd1);

    // Five characters at full rate through the 2-bit offset instance.
    do_reset();
    char_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(2 * i + 1), 1'b0); #1;
      if (i > 0) begin
        chk("t5_valid", 32'(o_valid), 32'd1);
        chk("t5_off",   32'(o_off),   32'((i - 1) % 4));
        chk("t5_first", 32'(o_first), 32'(i == 1));
        chk("t5_char",  32'(o_char),  32'({8'(2 * i - 1), 8'(2 * i)}));
      end
      step();
      drive(1'b1, 8'(2 * i + 2), i == 4);
      step();
    end
    drive(1'b0, 8'h00, 1'b0); #1;
    chk("t5_off_wrap", 32'(o_off),   32'd0);
    chk("t5_first4",   32'(o_first), 32'd0);
    chk("t5_char4",    32'(o_char),  32'h090a);
    chk("t5_wide_off", b_off,        32'd4);

    // Reset mid-pair discards the pending high byte.
    do_reset();
    drive(1'b1, 8'h41, 1'b0);
    step(); drive(1'b0, 8'h00, 1'b0); reset = 1'b1;
    step(); reset = 1'b0; #1;
    chk("t6_valid0",   32'(b_valid), 32'd0);
    chk("t6_ready",    32'(b_ready), 32'd1);
    drive(1'b1, 8'h54, 1'b0);
    step(); drive(1'b1, 8'h47, 1'b1);
    step(); drive(1'b0, 8'h00, 1'b0); #1;
    chk("t6_char",     32'(b_char),  32'h5447);
    chk("t6_valid",    32'(b_valid), 32'd1);
    chk("t6_first",    32'(b_first), 32'd1);
    chk("t6_off",      b_off,        32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
